ifetch_unit: RTL and testbench

- Consumer end of the next-PC path: owns the architectural PC register and loads the redirect target produced by next-PC logic on a taken branch or jump.
- Sequential fetch engine between the PC and the instruction ROM. Issues one outstanding IROM request at a time and tracks in-flight responses.
- Buffers fetched instructions in a small FIFO and hands them to decode with a valid/ready handshake.
- A redirect flushes the FIFO and drops any stale in-flight response.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/ifetch_unit.sv | 111 +++++++++++
 tb/tb_ifetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

    localparam int unsigned INST_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst} entries; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/ifetch_unit.sv
// Fetch engine: owns the PC, issues one IROM request at a time, buffers
// responses for decode, and flushes everything on a redirect.
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        irom_req_valid,
    output logic [31:0] irom_req_addr,
    input  logic        irom_req_ready,
    input  logic        irom_rsp_valid,
    input  logic [31:0] irom_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state_r;
    fetch_state_e    state_nxt_s;
    logic [31:0]     fetch_pc_r;
    logic [31:0]     req_pc_r;
    logic            accept_s;
    logic            push_s;
    logic            pop_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    fetch_entry_t    head_s;
    fetch_entry_t    push_entry_s;

    // A redirect cuts the request in the same cycle, so a stale address never gets accepted.
    assign irom_req_valid = !cpu_rst && (state_r == REQ) && !redir_valid
                            && (fifo_count_s < CW'(BUF_DEPTH));
    assign irom_req_addr  = fetch_pc_r;
    assign accept_s       = irom_req_valid && irom_req_ready;
    assign push_s         = (state_r == WAIT) && irom_rsp_valid && !redir_valid;
    assign pop_s          = inst_valid && inst_ready;
    assign push_entry_s   = '{pc: req_pc_r, inst: irom_rsp_data};

    // Next-state selection for the single-outstanding request tracker.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            REQ: begin
                if (accept_s) state_nxt_s = WAIT;
                else          state_nxt_s = REQ;
            end
            WAIT: begin
                if (irom_rsp_valid)   state_nxt_s = REQ;
                else if (redir_valid) state_nxt_s = DROP;
                else                  state_nxt_s = WAIT;
            end
            DROP: begin
                if (irom_rsp_valid) state_nxt_s = REQ;
                else                state_nxt_s = DROP;
            end
            default: state_nxt_s = REQ;
        endcase
    end

    // State, fetch PC and the PC of the request in flight.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_r    <= REQ;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            if (redir_valid) begin
                fetch_pc_r <= align_pc(redir_pc);
            end else if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 32'(INST_BYTES);
            end else begin
                fetch_pc_r <= fetch_pc_r;
            end
            if (accept_s) begin
                req_pc_r <= fetch_pc_r;
            end else begin
                req_pc_r <= req_pc_r;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (cpu_clk),
        .rst       (cpu_rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redir_valid),
        .head      (head_s),
        .count     (fifo_count_s),
        .empty     (fifo_empty_s)
    );

    assign inst_valid = !fifo_empty_s;
    assign inst       = head_s.inst;
    assign inst_pc    = head_s.pc;
    assign inst_pc4   = head_s.pc + 32'(INST_BYTES);

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench: behavioural IROM plus program-order PC model, with a
// scoreboard queue of expected decode entries checked by a separate monitor.
module tb_ifetch_unit;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        irom_req_valid;
    logic [31:0] irom_req_addr;
    logic        irom_req_ready;
    logic        irom_rsp_valid;
    logic [31:0] irom_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    always #5 cpu_clk = ~cpu_clk;

    ifetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .irom_req_valid (irom_req_valid),
        .irom_req_addr  (irom_req_addr),
        .irom_req_ready (irom_req_ready),
        .irom_rsp_valid (irom_rsp_valid),
        .irom_rsp_data  (irom_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4)
    );

    int checks = 0;
    int fails  = 0;

    // Expected decode stream: {pc, inst}, in program order.
    logic [63:0] exp_q [$];

    // Reference model state.
    logic [31:0] m_pc;        // next address the fetcher must request
    bit          busy;        // a request is outstanding from the fetcher's view
    bit          stale;       // that outstanding response must be dropped
    bit          pend;        // IROM holds a pending response (possibly orphaned by reset)
    int          pend_cnt;
    logic [31:0] pend_pc;

    int p_ready, p_inst_ready, p_redir, max_delay;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever decode takes the head, compare it with the scoreboard front.
    always @(negedge cpu_clk) begin
        logic [63:0] e;
        #2;
        if (!cpu_rst && inst_valid && inst_ready && !redir_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL pop_unexpected: got inst_pc %h, expected no entry", inst_pc);
            end else begin
                e = exp_q.pop_front();
                chk("inst_pc", inst_pc, e[63:32]);
                chk("inst", inst, e[31:0]);
                chk("inst_pc4", inst_pc4, e[63:32] + 32'd4);
            end
        end
    end

    task automatic cycle();
        @(negedge cpu_clk);
        irom_rsp_valid = pend && (pend_cnt == 0);
        irom_rsp_data  = irom_rsp_valid ? rom(pend_pc) : $urandom;
        irom_req_ready = !pend && ($urandom_range(99) < p_ready);
        redir_valid    = ($urandom_range(999) < p_redir);
        redir_pc       = $urandom_range(1) ? ($urandom & 32'h0000_0FFF)
                                           : (32'hFFFF_FFF0 | ($urandom & 32'hF));
        inst_ready     = ($urandom_range(99) < p_inst_ready);
        #1;
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
        chk("req_valid", {31'd0, irom_req_valid},
            {31'd0, !busy && !redir_valid && (exp_q.size() < 2)});
        if (irom_req_valid) chk("req_addr", irom_req_addr, m_pc);
        if (irom_rsp_valid) begin
            pend = 1'b0;
            if (busy) begin
                if (!stale && !redir_valid) exp_q.push_back({pend_pc, rom(pend_pc)});
                busy  = 1'b0;
                stale = 1'b0;
            end
        end else if (pend) begin
            pend_cnt--;
        end
        if (redir_valid) begin
            exp_q.delete();
            m_pc = redir_pc & 32'hFFFF_FFFC;
            if (busy) stale = 1'b1;
        end
        if (irom_req_valid && irom_req_ready) begin
            busy     = 1'b1;
            stale    = 1'b0;
            pend     = 1'b1;
            pend_cnt = int'($urandom_range(max_delay - 1, 0));
            pend_pc  = m_pc;
            m_pc     = m_pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        cpu_rst        = 1'b1;
        redir_valid    = 1'b0;
        irom_rsp_valid = 1'b0;
        irom_req_ready = 1'b0;
        inst_ready     = 1'b0;
        #1;
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_req_valid", {31'd0, irom_req_valid}, 32'd0);
        chk("rst_inst", inst, 32'h0000_0000);
        chk("rst_inst_pc", inst_pc, 32'h0000_0000);
        chk("rst_inst_pc4", inst_pc4, 32'h0000_0004);
        exp_q.delete();
        busy  = 1'b0;
        stale = 1'b0;
        m_pc  = 32'h0000_0000;
        repeat (2) @(negedge cpu_clk);
        cpu_rst = 1'b0;
    endtask

    task automatic run(input int n, input int rdy, input int irdy, input int rdr, input int dly);
        p_ready      = rdy;
        p_inst_ready = irdy;
        p_redir      = rdr;
        max_delay    = dly;
        repeat (n) cycle();
    endtask

    initial begin
        cpu_rst        = 1'b1;
        redir_valid    = 1'b0;
        redir_pc       = 32'h0000_0000;
        irom_req_ready = 1'b0;
        irom_rsp_valid = 1'b0;
        irom_rsp_data  = 32'h0000_0000;
        inst_ready     = 1'b0;
        pend           = 1'b0;
        pend_cnt       = 0;
        pend_pc        = 32'h0000_0000;
        do_reset();

        run(20, 100, 100, 0, 1);     // back-to-back sequential fetch
        run(20, 100, 0, 0, 1);       // decode stalled: FIFO fills, requests stop
        run(10, 100, 100, 0, 1);     // decode resumes
        run(1500, 60, 60, 50, 3);    // mixed stalls, delays and redirects

        p_redir = 0;
        for (int i = 0; i < 50 && !busy; i++) cycle();
        do_reset();                  // reset with a response still in flight
        run(300, 70, 70, 30, 3);
        run(500, 80, 80, 300, 3);    // redirect-heavy traffic
        run(20, 100, 100, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
